instr_fetch: RTL and testbench

//  Stage-1 fetch unit; consumer of the PC unit's PC_Out. Issues one I-cache

---
 rtl/instr_fetch.sv | 123 ++++++++++++
 tb/tb_instr_fetch.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Stage-1 fetch: one outstanding I-cache read at a time, results buffered in a small FIFO
// and handed to stage 2 via valid/ready. A PC_Sel redirect flushes buffered and in-flight work.
module instr_fetch #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_In,
    input  logic        PC_Sel,
    output logic        PC_Stall,
    output logic [31:0] icache_addr,
    output logic        icache_re,
    input  logic        icache_stall,
    input  logic [31:0] icache_dout,
    output logic        Inst_Valid,
    input  logic        Inst_Ready,
    output logic [31:0] Inst_Out,
    output logic [31:0] Inst_PC
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

    state_e        state_q, state_d;
    logic [31:0]   req_pc_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_after;
    logic [31:0]   pc_buf   [DEPTH];
    logic [31:0]   inst_buf [DEPTH];

    logic valid, pop, ret, push, accept;

    assign valid       = (count_q != '0);
    assign pop         = valid && Inst_Ready && !PC_Sel;
    assign ret         = (state_q == StWait) && !icache_stall;
    assign push        = ret && !PC_Sel;
    // Occupancy after this cycle's push/pop; a new request may only claim a free slot.
    assign count_after = count_q + CW'(push) - CW'(pop);
    assign accept      = icache_re && !icache_stall;

    always_comb begin
        state_d   = state_q;
        icache_re = 1'b0;
        unique case (state_q)
            StIdle: state_d = StReq;
            StReq: begin
                if (!PC_Sel && (count_after < FULL)) begin
                    icache_re = 1'b1;
                end
                if (icache_re && !icache_stall) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (!icache_stall) begin
                    if (PC_Sel) begin
                        state_d = StReq;
                    end else if (count_after < FULL) begin
                        icache_re = 1'b1;
                    end else begin
                        state_d = StReq;
                    end
                end else if (PC_Sel) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (!icache_stall) begin
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Idle only exists right after reset; keep the PC unit frozen there regardless of PC_Sel.
    assign PC_Stall    = (state_q == StIdle) || (!accept && !PC_Sel);
    assign icache_addr = PC_In;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            req_pc_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_pc_q <= PC_In;
            end
            if (PC_Sel) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                count_q <= count_after;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_buf[wr_ptr_q]   <= req_pc_q;
            inst_buf[wr_ptr_q] <= icache_dout;
        end
    end

    assign Inst_Valid = valid;
    assign Inst_Out   = valid ? inst_buf[rd_ptr_q] : NOP_INST;
    assign Inst_PC    = valid ? pc_buf[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: PC-unit and pipelined I-cache models, a scoreboard of expected
// {PC, instruction} pairs, a cycle table for streaming/back-pressure, and corner sequences.
module tb_instr_fetch;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc;
    logic [31:0] target = 32'h3000;
    logic        PC_Sel, Inst_Ready, icache_stall;
    logic        PC_Stall, icache_re, Inst_Valid;
    logic [31:0] icache_addr, icache_dout, Inst_Out, Inst_PC;
    logic [31:0] lat_addr = 32'h0;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

    typedef struct packed {
        logic        sel;
        logic        rdy;
        logic        stl;
        logic        e_re;
        logic        e_pcst;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;
    vec_t vec [13];

    instr_fetch #(
        .DEPTH    (DEPTH),
        .NOP_INST (NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .PC_In        (pc),
        .PC_Sel       (PC_Sel),
        .PC_Stall     (PC_Stall),
        .icache_addr  (icache_addr),
        .icache_re    (icache_re),
        .icache_stall (icache_stall),
        .icache_dout  (icache_dout),
        .Inst_Valid   (Inst_Valid),
        .Inst_Ready   (Inst_Ready),
        .Inst_Out     (Inst_Out),
        .Inst_PC      (Inst_PC)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // Cache returns data for the last accepted address; garbage while stalled.
    assign icache_dout = icache_stall ? 32'hDEAD_BEEF : inst_of(lat_addr);

    always @(posedge clk) begin
        if (icache_re && !icache_stall) lat_addr <= icache_addr;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset)         pc <= 32'h2000;
        else if (PC_Sel)    pc <= target;
        else if (!PC_Stall) pc <= pc + 32'd4;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset && Inst_Valid && Inst_Ready && !PC_Sel) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: popped pc %h, want nothing", Inst_PC);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_pc", Inst_PC, mon_e.pc);
                chk("sb_inst", Inst_Out, mon_e.inst);
            end
        end
    end

    task automatic drive(input logic s, input logic r, input logic t);
        PC_Sel       = s;
        Inst_Ready   = r;
        icache_stall = t;
    endtask

    task automatic next(input logic s, input logic r, input logic t);
        @(posedge clk);
        #1;
        drive(s, r, t);
        @(negedge clk);
    endtask

    task automatic release_rst(input logic s, input logic r, input logic t);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(s, r, t);
        @(negedge clk);
    endtask

    task automatic fill(input logic [31:0] start, input int n);
        for (int k = 0; k < n; k++) begin
            sbq.push_back({start + 32'(4 * k), inst_of(start + 32'(4 * k))});
        end
    endtask

    task automatic hold_reset(input int n);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        sbq.delete();
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t exceeded", $time);
        $fatal(1);
    end

    initial begin
        //          sel   rdy   stl   re    pcst  valid pc
        vec[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
        vec[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vec[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vec[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2000};
        vec[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2004};
        vec[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2008};
        vec[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200C};
        vec[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200C};
        vec[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200C};
        vec[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200C};
        vec[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200C};
        vec[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200C};
        vec[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2010};

        drive(1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            drive(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
            @(negedge clk);
            chk("rst_valid", Inst_Valid, 32'h0);
            chk("rst_out", Inst_Out, NOP);
            chk("rst_pc", Inst_PC, 32'h0);
            chk("rst_re", icache_re, 32'h0);
            chk("rst_pcstall", PC_Stall, 32'h1);
        end

        // Streaming then back-pressure, cycle by cycle
        hold_reset(2);
        fill(32'h2000, 24);
        for (int i = 0; i < 13; i++) begin
            if (i == 0) release_rst(vec[i].sel, vec[i].rdy, vec[i].stl);
            else        next(vec[i].sel, vec[i].rdy, vec[i].stl);
            chk($sformatf("tbl%0d_re", i), icache_re, 32'(vec[i].e_re));
            chk($sformatf("tbl%0d_pcstall", i), PC_Stall, 32'(vec[i].e_pcst));
            chk($sformatf("tbl%0d_valid", i), Inst_Valid, 32'(vec[i].e_valid));
            if (vec[i].e_valid) begin
                chk($sformatf("tbl%0d_pc", i), Inst_PC, vec[i].e_pc);
                chk($sformatf("tbl%0d_inst", i), Inst_Out, inst_of(vec[i].e_pc));
            end else begin
                chk($sformatf("tbl%0d_nop", i), Inst_Out, NOP);
            end
        end

        // Cache stall during WAIT
        hold_reset(2);
        fill(32'h2000, 8);
        release_rst(1'b0, 1'b0, 1'b0);
        chk("cs_idle_re", icache_re, 32'h0);
        next(1'b0, 1'b0, 1'b0);
        chk("cs_first_re", icache_re, 32'h1);
        chk("cs_first_addr", icache_addr, 32'h2000);
        for (int i = 0; i < 5; i++) begin
            next(1'b0, 1'b0, 1'b1);
            chk("cs_pcstall", PC_Stall, 32'h1);
            chk("cs_addr_hold", icache_addr, 32'h2004);
            chk("cs_no_valid", Inst_Valid, 32'h0);
        end
        next(1'b0, 1'b0, 1'b0);
        chk("cs_reissue", icache_re, 32'h1);
        chk("cs_valid_lat", Inst_Valid, 32'h0);
        next(1'b0, 1'b1, 1'b1);
        chk("cs_valid", Inst_Valid, 32'h1);
        chk("cs_pc", Inst_PC, 32'h2000);
        next(1'b0, 1'b1, 1'b1);
        chk("cs_one_push", Inst_Valid, 32'h0);

        // Flush with two buffered and one outstanding
        hold_reset(2);
        fill(32'h2000, 8);
        release_rst(1'b0, 1'b0, 1'b0);
        next(1'b0, 1'b0, 1'b0);
        next(1'b0, 1'b0, 1'b0);
        next(1'b0, 1'b0, 1'b0);
        chk("fl_valid_pre", Inst_Valid, 32'h1);
        next(1'b1, 1'b0, 1'b1);
        chk("fl_sel_re", icache_re, 32'h0);
        chk("fl_sel_pcstall", PC_Stall, 32'h0);
        chk("fl_sel_head", Inst_PC, 32'h2000);
        sbq.delete();
        fill(32'h3000, 8);
        next(1'b0, 1'b1, 1'b0);
        chk("fl_flushed", Inst_Valid, 32'h0);
        chk("fl_drop_re", icache_re, 32'h0);
        chk("fl_drop_pcstall", PC_Stall, 32'h1);
        next(1'b0, 1'b1, 1'b0);
        chk("fl_new_re", icache_re, 32'h1);
        chk("fl_new_addr", icache_addr, 32'h3000);
        next(1'b0, 1'b1, 1'b0);
        chk("fl_stale_dropped", Inst_Valid, 32'h0);
        next(1'b0, 1'b1, 1'b0);
        chk("fl_valid", Inst_Valid, 32'h1);
        chk("fl_pc", Inst_PC, 32'h3000);

        // Reset asserted while a request is outstanding
        hold_reset(2);
        fill(32'h2000, 8);
        release_rst(1'b0, 1'b0, 1'b0);
        next(1'b0, 1'b0, 1'b0);
        next(1'b0, 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("rm_valid", Inst_Valid, 32'h0);
        chk("rm_re", icache_re, 32'h0);
        chk("rm_pcstall", PC_Stall, 32'h1);
        chk("rm_out", Inst_Out, NOP);
        sbq.delete();
        fill(32'h2000, 8);
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        release_rst(1'b0, 1'b0, 1'b0);
        next(1'b0, 1'b0, 1'b1);
        chk("rm_late_valid", Inst_Valid, 32'h0);
        chk("rm_late_out", Inst_Out, NOP);
        next(1'b0, 1'b0, 1'b1);
        chk("rm_late_valid2", Inst_Valid, 32'h0);
        next(1'b0, 1'b1, 1'b0);
        next(1'b0, 1'b1, 1'b0);
        next(1'b0, 1'b1, 1'b0);
        chk("rm_valid_after", Inst_Valid, 32'h1);
        chk("rm_pc_after", Inst_PC, 32'h2000);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
